// File: rtl/llr_loader_pkg.sv
// Shared constants for the LLR loader: FSM encodings and chunk geometry helpers.
package llr_loader_pkg;

  localparam logic [1:0] FILL     = 2'b00;
  localparam logic [1:0] WAIT_DEC = 2'b01;
  localparam logic [1:0] SEND     = 2'b10;

  // Number of LLRs in the leading (possibly short) chunk.
  function automatic int first_len(input int n_v, input int n_llrs);
    return ((n_v - 1) % n_llrs) + 1;
  endfunction

  function automatic int seg_count(input int n_v, input int n_llrs);
    return (n_v - 1) / n_llrs;
  endfunction

  function automatic int chunk_width(input int n_llrs, input int width_in);
    return n_llrs * width_in;
  endfunction

endpackage

// File: rtl/llr_loader_if.sv
// Sample-side and decoder-side signal bundle for the LLR loader.
interface llr_loader_if #(
  parameter int WIDTH_SAMPLE = 12,
  parameter int WIDTH_IN     = 8,
  parameter int N_LLRS       = 4,
  parameter int SAT_W        = 8
);
  logic signed [WIDTH_SAMPLE-1:0]  sample_in;
  logic                            sample_valid;
  logic                            sample_last;
  logic                            sample_ready;
  logic                            dec_busy;
  logic [N_LLRS*WIDTH_IN-1:0]      databus_out;
  logic                            first_data;
  logic                            data_valid;
  logic                            frame_err;
  logic [SAT_W-1:0]                sat_cnt;

  modport master (
    output sample_in, sample_valid, sample_last, dec_busy,
    input  sample_ready, databus_out, first_data, data_valid, frame_err, sat_cnt
  );

  modport slave (
    input  sample_in, sample_valid, sample_last, dec_busy,
    output sample_ready, databus_out, first_data, data_valid, frame_err, sat_cnt
  );
endinterface

// File: rtl/llr_quantizer.sv
// Shift/saturate a channel sample into a symmetric LLR and flag saturation.
// LLR_LOADER_ROUND_EN selects round-half-up instead of floor truncation.
module llr_quantizer #(
  parameter int WIDTH_SAMPLE = 12,
  parameter int WIDTH_IN     = 8,
  parameter int FRAC_DROP    = 4
) (
  input  logic signed [WIDTH_SAMPLE-1:0] sample_in,
  output logic signed [WIDTH_IN-1:0]     llr,
  output logic                           sat
);
  // One guard bit so the rounding offset cannot wrap the sample.
  localparam int QW = WIDTH_SAMPLE + 1;
  localparam logic signed [QW-1:0] LLR_MAX = QW'(2**(WIDTH_IN-1) - 1);
  localparam logic signed [QW-1:0] LLR_MIN = -LLR_MAX;

  logic signed [QW-1:0] ext;
  logic signed [QW-1:0] q;

  assign ext = {sample_in[WIDTH_SAMPLE-1], sample_in};

`ifdef LLR_LOADER_ROUND_EN
  localparam logic signed [QW-1:0] HALF = QW'(2**(FRAC_DROP-1));
  assign q = (ext + HALF) >>> FRAC_DROP;
`else
  assign q = ext >>> FRAC_DROP;
`endif

  always_comb begin
    sat = 1'b0;
    llr = q[WIDTH_IN-1:0];
    if (q > LLR_MAX) begin
      sat = 1'b1;
      llr = LLR_MAX[WIDTH_IN-1:0];
    end else if (q < LLR_MIN) begin
      sat = 1'b1;
      llr = LLR_MIN[WIDTH_IN-1:0];
    end
  end
endmodule

// File: rtl/llr_loader.sv
// Buffers one quantized codeword and bursts it into the decoder's chunked LLR bus.
// LLR_LOADER_ROUND_EN (in llr_quantizer) switches floor to round-half-up.
module llr_loader
  import llr_loader_pkg::*;
#(
  parameter int WIDTH_SAMPLE = 12,
  parameter int WIDTH_IN     = 8,
  parameter int N_LLRS       = 4,
  parameter int N_V          = 31,
  parameter int FRAC_DROP    = 4,
  parameter int SAT_W        = 8
) (
  input logic         clk,
  input logic         rst,
  llr_loader_if.slave bus
);
  localparam int F_LEN   = first_len(N_V, N_LLRS);
  localparam int L_SEG   = seg_count(N_V, N_LLRS);
  localparam int CHUNK_W = chunk_width(N_LLRS, WIDTH_IN);
  localparam int IDX_W   = (N_V > 1) ? $clog2(N_V) : 1;
  localparam int CNT_W   = $clog2(L_SEG + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_V - 1);
  localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(L_SEG + 1);

  logic [1:0]               state_reg;
  logic [IDX_W-1:0]         fill_cnt_reg;
  logic [CNT_W-1:0]         chunk_cnt_reg;
  logic [SAT_W-1:0]         run_sat_reg;
  logic [SAT_W-1:0]         run_sat_next;
  logic [SAT_W-1:0]         sat_cnt_reg;
  logic                     frame_err_reg;
  logic                     first_data_reg;
  logic                     data_valid_reg;
  logic [CHUNK_W-1:0]       databus_reg;
  logic [CHUNK_W-1:0]       chunk_next;
  logic [WIDTH_IN-1:0]      llr_mem [N_V];
  logic signed [WIDTH_IN-1:0] q_llr;
  logic                     q_sat;
  logic                     accept;
  logic [CNT_W-1:0]         chunk_sel;

  llr_quantizer #(
    .WIDTH_SAMPLE(WIDTH_SAMPLE),
    .WIDTH_IN    (WIDTH_IN),
    .FRAC_DROP   (FRAC_DROP)
  ) u_quant (
    .sample_in(bus.sample_in),
    .llr      (q_llr),
    .sat      (q_sat)
  );

  assign bus.sample_ready = (state_reg == FILL) && !rst;
  assign accept           = bus.sample_valid && bus.sample_ready;
  assign run_sat_next     = (q_sat && (run_sat_reg != '1)) ? run_sat_reg + 1'b1 : run_sat_reg;
  // chunk_cnt_reg holds the index of the next chunk to stage while in SEND.
  assign chunk_sel        = (state_reg == SEND) ? chunk_cnt_reg : '0;

  // Earlier LLRs land in higher lanes; out-of-range indices read as zero.
  for (genvar gi = 0; gi < N_LLRS; gi++) begin : g_lane
    localparam int HEAD_IDX = F_LEN - 1 - gi;
    logic [WIDTH_IN-1:0] lane_val;

    always_comb begin
      int idx;
      idx = (chunk_sel == '0) ? HEAD_IDX
                              : F_LEN + (int'(chunk_sel) - 1) * N_LLRS + (N_LLRS - 1 - gi);
      lane_val = '0;
      if (idx >= 0 && idx < N_V) lane_val = llr_mem[IDX_W'(idx)];
    end

    assign chunk_next[gi*WIDTH_IN +: WIDTH_IN] = lane_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= FILL;
      fill_cnt_reg   <= '0;
      chunk_cnt_reg  <= '0;
      run_sat_reg    <= '0;
      sat_cnt_reg    <= '0;
      frame_err_reg  <= 1'b0;
      first_data_reg <= 1'b0;
      data_valid_reg <= 1'b0;
      databus_reg    <= '0;
      for (int i = 0; i < N_V; i++) llr_mem[i] <= '0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        FILL: begin
          if (accept) begin
            llr_mem[fill_cnt_reg] <= q_llr;
            if (fill_cnt_reg == LAST_IDX) begin
              sat_cnt_reg  <= run_sat_next;
              run_sat_reg  <= '0;
              fill_cnt_reg <= '0;
              state_reg    <= WAIT_DEC;
            end else if (bus.sample_last) begin
              frame_err_reg <= 1'b1;
              run_sat_reg   <= '0;
              fill_cnt_reg  <= '0;
            end else begin
              run_sat_reg  <= run_sat_next;
              fill_cnt_reg <= fill_cnt_reg + 1'b1;
            end
          end
        end
        WAIT_DEC: begin
          if (!bus.dec_busy) begin
            databus_reg    <= chunk_next;
            first_data_reg <= 1'b1;
            data_valid_reg <= 1'b1;
            chunk_cnt_reg  <= CNT_W'(1);
            state_reg      <= SEND;
          end
        end
        SEND: begin
          if (chunk_cnt_reg == END_CNT) begin
            databus_reg    <= '0;
            first_data_reg <= 1'b0;
            data_valid_reg <= 1'b0;
            chunk_cnt_reg  <= '0;
            state_reg      <= FILL;
          end else begin
            databus_reg    <= chunk_next;
            first_data_reg <= 1'b0;
            chunk_cnt_reg  <= chunk_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign bus.databus_out = databus_reg;
  assign bus.first_data  = first_data_reg;
  assign bus.data_valid  = data_valid_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.sat_cnt     = sat_cnt_reg;
endmodule

// File: tb/tb_llr_loader.sv
// Directed self-checking bench for llr_loader: fill, burst, saturation, rounding, errors, reset.
module tb_llr_loader;
  localparam int WS = 12;
  localparam int WI = 8;
  localparam int NL = 4;
  localparam int NV = 31;
  localparam int FD = 4;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  llr_loader_if #(.WIDTH_SAMPLE(WS), .WIDTH_IN(WI), .N_LLRS(NL), .SAT_W(SW)) bus ();

  llr_loader #(
    .WIDTH_SAMPLE(WS), .WIDTH_IN(WI), .N_LLRS(NL), .N_V(NV), .FRAC_DROP(FD), .SAT_W(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic signed [WS-1:0] smp     [NV];
  logic [WI-1:0]        exp_llr [NV];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic signed [WS-1:0] v, input logic last);
    bus.sample_in    = v;
    bus.sample_valid = 1'b1;
    bus.sample_last  = last;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.sample_last  = 1'b0;
  endtask

  task automatic ramp(input int dir);
    for (int i = 0; i < NV; i++) begin
      smp[i]     = (dir == 0) ? WS'(i * 16) : WS'((NV - 1 - i) * 16);
      exp_llr[i] = (dir == 0) ? WI'(i) : WI'(NV - 1 - i);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < NV; i++) push(smp[i], i == NV - 1);
  endtask

  function automatic logic [31:0] exp_chunk(input int k);
    logic [31:0] r;
    int idx;
    r = '0;
    for (int j = 0; j < NL; j++) begin
      idx = (k == 0) ? 2 - j : 3 + (k - 1) * 4 + 3 - j;
      if (idx >= 0 && idx < NV) r[j*8 +: 8] = exp_llr[idx];
    end
    return r;
  endfunction

  task automatic wait_first(input int budget);
    int n;
    n = 0;
    while (bus.first_data !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("first_data_seen", 32'(bus.first_data), 32'd1);
  endtask

  task automatic check_burst(input string tag);
    for (int k = 0; k <= 7; k++) begin
      $display("%s chunk %0d: data=%h first=%b valid=%b", tag, k, bus.databus_out,
               bus.first_data, bus.data_valid);
      chk({tag, "_valid"}, 32'(bus.data_valid), 32'd1);
      chk({tag, "_first"}, 32'(bus.first_data), (k == 0) ? 32'd1 : 32'd0);
      chk({tag, "_data"}, bus.databus_out, exp_chunk(k));
      @(negedge clk);
    end
    chk({tag, "_valid_end"}, 32'(bus.data_valid), 32'd0);
    chk({tag, "_ready_end"}, 32'(bus.sample_ready), 32'd1);
  endtask

  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.sample_last  = 1'b0;
    bus.dec_busy     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.sample_ready), 32'd0);
    chk("rst_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_first", 32'(bus.first_data), 32'd0);
    chk("rst_data", bus.databus_out, 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    chk("rst_sat", 32'(bus.sat_cnt), 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_ready", 32'(bus.sample_ready), 32'd1);
    @(negedge clk);

    // Full frame: i*16 -> LLR i, checks two-cycle latency from the closing sample
    ramp(0);
    push_frame();
    chk("full_wait_ready", 32'(bus.sample_ready), 32'd0);
    chk("full_no_first_yet", 32'(bus.first_data), 32'd0);
    @(negedge clk);
    chk("full_first_latency", 32'(bus.first_data), 32'd1);
    chk("full_chunk0_hand", bus.databus_out, 32'h0000_0102);
    check_burst("full");
    chk("full_sat", 32'(bus.sat_cnt), 32'd0);

    // Saturation: 2047 -> +127 (exact), -2048 -> -127 (saturated)
    ramp(0);
    smp[0] = WS'(2047);
    smp[1] = WS'(-2048);
    exp_llr[0] = 8'h7F;
    exp_llr[1] = 8'h81;
    push_frame();
    wait_first(4);
    chk("sat_chunk0_hand", bus.databus_out, 32'h007F_8102);
    check_burst("sat");
    chk("sat_cnt", 32'(bus.sat_cnt), 32'd1);

    // Rounding: 40 and -24
    ramp(0);
    smp[0] = WS'(40);
    smp[1] = WS'(-24);
`ifdef LLR_LOADER_ROUND_EN
    exp_llr[0] = 8'h03;
    exp_llr[1] = 8'hFF;
`else
    exp_llr[0] = 8'h02;
    exp_llr[1] = 8'hFE;
`endif
    push_frame();
    wait_first(4);
    check_burst("round");
    chk("round_sat", 32'(bus.sat_cnt), 32'd0);

    // Early last on the 10th sample, then a clean descending frame
    ramp(1);
    for (int i = 0; i < 10; i++) push(smp[i], i == 9);
    chk("early_err_pulse", 32'(bus.frame_err), 32'd1);
    chk("early_ready", 32'(bus.sample_ready), 32'd1);
    @(negedge clk);
    chk("early_err_clear", 32'(bus.frame_err), 32'd0);
    chk("early_no_first", 32'(bus.first_data), 32'd0);
    push_frame();
    wait_first(4);
    check_burst("after_early");

    // Decoder busy for 20 cycles; rejected samples with sample_last must be ignored
    ramp(0);
    bus.dec_busy = 1'b1;
    push_frame();
    for (int c = 0; c < 20; c++) begin
      bus.sample_in    = WS'(2047);
      bus.sample_valid = 1'b1;
      bus.sample_last  = 1'b1;
      @(negedge clk);
      chk("busy_valid", 32'(bus.data_valid), 32'd0);
      chk("busy_ready", 32'(bus.sample_ready), 32'd0);
      chk("busy_err", 32'(bus.frame_err), 32'd0);
    end
    bus.sample_valid = 1'b0;
    bus.sample_last  = 1'b0;
    bus.dec_busy     = 1'b0;
    @(negedge clk);
    chk("busy_first_latency", 32'(bus.first_data), 32'd1);
    check_burst("busy");

    // Reset during chunk 3
    ramp(0);
    push_frame();
    wait_first(4);
    repeat (3) @(negedge clk);
    chk("mid_chunk3", bus.databus_out, exp_chunk(3));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.data_valid), 32'd0);
    chk("mid_rst_first", 32'(bus.first_data), 32'd0);
    chk("mid_rst_ready", 32'(bus.sample_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_release_ready", 32'(bus.sample_ready), 32'd1);
    @(negedge clk);
    chk("mid_idle_valid", 32'(bus.data_valid), 32'd0);
    ramp(1);
    push_frame();
    wait_first(4);
    check_burst("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
